// File: rtl/cache_control_if.sv
// CPU-request, datapath-control and pmem signals of the L1 cache controller.
// The slave modport is the controller; the master modport is its environment.
interface cache_control_if #(
    parameter int unsigned S_MASK = 32
);
    logic              mem_read;
    logic              mem_write;
    logic [S_MASK-1:0] mem_byte_enable;
    logic              mem_resp;
    logic              hit0;
    logic              hit1;
    logic              dirty0;
    logic              dirty1;
    logic              lru;
    logic              way_sel;
    logic [S_MASK-1:0] data_we;
    logic              line_sel;
    logic              tag_load;
    logic              valid_load;
    logic              dirty_load;
    logic              lru_load;
    logic              dirty_in;
    logic              lru_in;
    logic              addr_sel;
    logic              pmem_read;
    logic              pmem_write;
    logic              pmem_resp;
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;

    modport slave (
        input  mem_read, mem_write, mem_byte_enable,
        input  hit0, hit1, dirty0, dirty1, lru, pmem_resp,
        output mem_resp, way_sel, data_we, line_sel,
        output tag_load, valid_load, dirty_load, lru_load, dirty_in, lru_in,
        output addr_sel, pmem_read, pmem_write, hit_count, miss_count
    );

    modport master (
        output mem_read, mem_write, mem_byte_enable,
        output hit0, hit1, dirty0, dirty1, lru, pmem_resp,
        input  mem_resp, way_sel, data_we, line_sel,
        input  tag_load, valid_load, dirty_load, lru_load, dirty_in, lru_in,
        input  addr_sel, pmem_read, pmem_write, hit_count, miss_count
    );
endinterface

// File: rtl/cache_control.sv
// Sequencing FSM for a 2-way write-back L1: hit handling, dirty-victim
// writeback, line fill, and saturating hit/miss counters.
module cache_control #(
    parameter int unsigned S_MASK = 32
) (
    input logic           clk,
    input logic           rst,
    cache_control_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;

    state_t            state_q, state_d;
    logic              v_q, v_d;
    logic              req, hit, victim_dirty, miss_evt;
    logic [S_MASK-1:0] we;
    logic [31:0]       hit_cnt, miss_cnt, hit_next, miss_next;

    assign req          = bus.mem_read | bus.mem_write;
    assign hit          = bus.hit0 | bus.hit1;
    assign victim_dirty = bus.lru ? bus.dirty1 : bus.dirty0;
    assign bus.data_we    = we;
    assign bus.hit_count  = hit_cnt;
    assign bus.miss_count = miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            v_q      <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            state_q  <= state_d;
            v_q      <= v_d;
            hit_cnt  <= hit_next;
            miss_cnt <= miss_next;
        end
    end

    always_comb begin
        state_d        = state_q;
        v_d            = v_q;
        miss_evt       = 1'b0;
        we             = '0;
        bus.mem_resp   = 1'b0;
        bus.way_sel    = 1'b0;
        bus.line_sel   = 1'b0;
        bus.tag_load   = 1'b0;
        bus.valid_load = 1'b0;
        bus.dirty_load = 1'b0;
        bus.lru_load   = 1'b0;
        bus.dirty_in   = 1'b0;
        bus.lru_in     = 1'b0;
        bus.addr_sel   = 1'b0;
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) state_d = COMPARE;
            end
            COMPARE: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (hit) begin
                    bus.way_sel  = bus.hit1;
                    bus.lru_load = 1'b1;
                    bus.lru_in   = ~bus.hit1;
                    bus.mem_resp = 1'b1;
                    // A simultaneous read+write request is serviced as a write.
                    if (bus.mem_write) begin
                        we             = bus.mem_byte_enable;
                        bus.dirty_load = 1'b1;
                        bus.dirty_in   = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    miss_evt = 1'b1;
                    v_d      = bus.lru;
                    state_d  = victim_dirty ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                bus.way_sel    = v_q;
                bus.addr_sel   = 1'b1;
                bus.pmem_write = 1'b1;
                if (bus.pmem_resp) state_d = FILL;
            end
            FILL: begin
                bus.way_sel   = v_q;
                bus.pmem_read = 1'b1;
                if (bus.pmem_resp) begin
                    bus.line_sel   = 1'b1;
                    we             = '1;
                    bus.tag_load   = 1'b1;
                    bus.valid_load = 1'b1;
                    bus.dirty_load = 1'b1;
                    state_d        = COMPARE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hit_next  = hit_cnt;
        miss_next = miss_cnt;
        if (bus.mem_resp && hit_cnt != '1) hit_next  = hit_cnt + 32'd1;
        if (miss_evt && miss_cnt != '1)    miss_next = miss_cnt + 32'd1;
    end
endmodule
